instr_fetch_ctrl: RTL and testbench



---
 rtl/fetch_pkg.sv | 5 +
 rtl/instr_fetch_ctrl_pc_gen.sv | 25 ++
 rtl/instr_fetch_ctrl.sv | 82 ++++++++
 tb/tb_instr_fetch_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch controller.
package fetch_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
  localparam int PC_STEP = 4;
endpackage

// File: rtl/instr_fetch_ctrl_pc_gen.sv
// pc_gen: program counter register with redirect / increment / hold selection.
module pc_gen
  import fetch_pkg::*;
#(
  parameter int ADDR_SIZE = 32,
  parameter logic [ADDR_SIZE-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_valid,
  input  logic [ADDR_SIZE-1:0] redirect_pc,
  input  logic                 advance,
  output logic [ADDR_SIZE-1:0] pc
);
  logic [ADDR_SIZE-1:0] pc_q, pc_d;
  always_comb begin
    pc_d = redirect_valid ? (redirect_pc & ~ADDR_SIZE'(3)) :
           advance        ? pc_q + ADDR_SIZE'(PC_STEP) : pc_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end
  assign pc = pc_q;
endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC sequencing, redirect/halt FSM and one-entry output register toward decode.
// Define FETCH_STALL_CNT_EN to add the saturating backpressure counter port stall_cnt.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_SIZE = 32,
  parameter int INSTR_WIDTH = 32,
  parameter logic [ADDR_SIZE-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR_SIZE-1:0]   imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  input  logic                   redirect_valid,
  input  logic [ADDR_SIZE-1:0]   redirect_pc,
  input  logic                   halt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_SIZE-1:0]   out_pc,
`ifdef FETCH_STALL_CNT_EN
  output logic [31:0]            stall_cnt,
`endif
  output logic                   halted
);
  fetch_state_t state_q, state_d;
  logic out_valid_q, out_valid_d;
  logic [INSTR_WIDTH-1:0] out_instr_q, out_instr_d;
  logic [ADDR_SIZE-1:0] out_pc_q, out_pc_d;
  logic [ADDR_SIZE-1:0] pc;
  logic fetch;

  pc_gen #(.ADDR_SIZE(ADDR_SIZE), .RESET_PC(RESET_PC)) u_pc_gen (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .advance(fetch), .pc(pc)
  );

  // Redirect outranks everything: it flushes the output and suppresses the fetch.
  always_comb begin
    fetch = state_q == RUN && !redirect_valid && (!out_valid_q || out_ready);
    state_d = redirect_valid ? RUN :
              state_q == BOOT ? RUN :
              (state_q == RUN && halt) ? HALT : state_q;
    out_valid_d = redirect_valid ? 1'b0 :
                  fetch ? 1'b1 :
                  out_ready ? 1'b0 : out_valid_q;
    out_instr_d = fetch ? imem_instr : out_instr_q;
    out_pc_d = fetch ? pc : out_pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q <= '0;
    end else begin
      state_q <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q <= out_pc_d;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  always_comb begin
    stall_cnt_d = (out_valid_q && !out_ready && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end
  assign stall_cnt = stall_cnt_q;
`endif

  assign imem_addr = pc;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc = out_pc_q;
  assign halted = state_q == HALT;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed + randomized stimulus against a spec-level model with a transfer scoreboard.
module tb_instr_fetch_ctrl;
  logic clk = 0, rst = 1;
  logic [31:0] imem_addr, imem_instr, redirect_pc = 0, out_instr, out_pc;
  logic redirect_valid = 0, halt = 0, out_ready = 0, out_valid, halted;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  instr_fetch_ctrl dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
`ifdef FETCH_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction
  assign imem_instr = mem_f(imem_addr);

  int checks = 0, errors = 0;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } item_t;
  item_t exp_q[$];

  // Reference model: 0 = booting, 1 = running, 2 = halted
  int m_st;
  logic m_valid;
  logic [31:0] m_pc, m_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_valid = 0; m_pc = 0; m_stall = 0;
    exp_q.delete();
  endtask

  // Applies the effect of the edge just passed, using the inputs that were present at it.
  task automatic model_step();
    bit fetch;
    fetch = m_st == 1 && !redirect_valid && (!m_valid || out_ready);
    if (m_valid && !out_ready && m_stall != 32'hFFFFFFFF) m_stall++;
    if (redirect_valid) begin
      m_pc = {redirect_pc[31:2], 2'b00};
      m_valid = 0;
      m_st = 1;
    end else begin
      if (fetch) begin
        exp_q.push_back('{m_pc, mem_f(m_pc)});
        m_valid = 1;
        m_pc += 4;
      end else if (m_valid && out_ready) m_valid = 0;
      if (m_st == 0) m_st = 1;
      else if (m_st == 1 && halt) m_st = 2;
    end
  endtask

  task automatic cyc(input bit rv, input logic [31:0] rpc, input bit h, input bit rdy);
    @(posedge clk);
    #1;
    model_step();
    redirect_valid = rv; redirect_pc = rpc; halt = h; out_ready = rdy;
  endtask

  // Monitor: compares state and pops the scoreboard whenever the output leaves the register.
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      check("halted", {31'b0, halted}, {31'b0, m_st == 2});
      check("imem_addr", imem_addr, m_pc);
`ifdef FETCH_STALL_CNT_EN
      check("stall_cnt", stall_cnt, m_stall);
`endif
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty: out_valid=1 with out_pc %h, expected nothing", out_pc);
        end else begin
          check("out_pc", out_pc, exp_q[0].pc);
          check("out_instr", out_instr, exp_q[0].instr);
          if (out_ready || redirect_valid) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    rst = 0;
    out_ready = 1;
    repeat (4) cyc(0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 1);
    cyc(1, 32'h40, 0, 1);
    repeat (3) cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    repeat (3) cyc(0, 0, 0, 1);
    cyc(1, 32'h83, 0, 1);
    repeat (2) cyc(0, 0, 0, 1);
    cyc(1, 32'hFFFFFFFC, 0, 1);
    repeat (3) cyc(0, 0, 0, 1);
    #2 rst = 1;
    #1;
    check("async_out_valid", {31'b0, out_valid}, 32'd0);
    check("async_imem_addr", imem_addr, 32'h0);
    model_reset();
    rst = 0;
    for (int i = 0; i < 3000; i++) begin
      bit rv;
      logic [31:0] rpc;
      rv = $urandom_range(0, 9) == 0;
      rpc = $urandom_range(0, 3) == 0 ? 32'hFFFFFFF0 | $urandom_range(0, 15) : $urandom;
      cyc(rv, rpc, $urandom_range(0, 11) == 0, $urandom_range(0, 9) < 7);
    end
    repeat (2) cyc(0, 0, 0, 1);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
